imem_responder: RTL and testbench

Responder side of the instruction-fetch interface. It serves word-addressed fetch requests from the fetch stage with a fixed, parameterised latency, and it holds the program in an internal single-port RAM. Before execution the RAM is filled through a byte-serial load port, for example from a UART receiver. It replaces the fixed program ROM, so programs can be loaded at run time without resynthesis.

---
 rtl/imem_pkg.sv | 21 ++
 rtl/imem_responder_ld_word_packer.sv | 46 ++++
 rtl/imem_responder.sv | 169 ++++++++++++++++
 tb/tb_imem_responder.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    LOAD = 2'd2
  } state_t;

  // Canonical RISC-V NOP (addi x0, x0, 0)
  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

  localparam int MAX_LATENCY = 8;

  // Width of a down-counter that must hold LATENCY-1 (at least one bit)
  function automatic int cnt_width(input int latency);
    if (latency <= 2) return 1;
    return $clog2(latency);
  endfunction

endpackage

// File: rtl/imem_responder_ld_word_packer.sv
// Assembles little-endian program bytes into 32-bit words for the RAM loader.
module ld_word_packer
  import imem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        push,
  input  logic        last,
  input  logic [7:0]  din,
  output logic        we,
  output logic [31:0] wdata
);

  logic [1:0]  lane;
  logic [31:0] acc_word;

  // Current byte merged into the partial word; lanes above it are already zero
  always_comb begin
    wdata = acc_word;
    wdata[{lane, 3'b000} +: 8] = din;
  end

  assign we = push && (last || (lane == 2'd3));

  // Lane pointer and partial word; cleared on every emitted word so that a
  // short final word is zero-padded without extra masking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane     <= 2'd0;
      acc_word <= '0;
    end else if (clr) begin
      lane     <= 2'd0;
      acc_word <= '0;
    end else if (push) begin
      if (we) begin
        lane     <= 2'd0;
        acc_word <= '0;
      end else begin
        lane     <= lane + 2'd1;
        acc_word <= wdata;
      end
    end
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction-fetch responder backed by a run-time loadable single-port RAM.
module imem_responder
  import imem_pkg::*;
#(
  parameter int          ADDR_W   = 14,
  parameter int          LATENCY  = 2,
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [29:0] req_addr,
  input  logic        flush,
  output logic        rsp_valid,
  output logic [31:0] rsp_inst,
  output logic        rsp_err,
  input  logic        ld_start,
  input  logic        ld_valid,
  input  logic [7:0]  ld_byte,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        ld_done,
  output logic        ld_ovf
);

  localparam int                CNT_W    = cnt_width(LATENCY);
  localparam int                LEN_W    = ADDR_W + 1;
  localparam int                DEPTH    = 1 << ADDR_W;
  localparam logic [LEN_W-1:0]  LEN_FULL = LEN_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [LEN_W-1:0]   ld_len;
  logic               ld_done_q;
  logic               ld_ovf_q;

  logic [31:0]        mem [DEPTH];
  logic [31:0]        ram_q;
  logic               err_q;
  logic [31:0]        inst_hold;
  logic               err_hold;

  logic               is_idle;
  logic               is_busy;
  logic               is_load;
  logic               rsp_slot;
  logic               acc;
  logic               rsp_fire;
  logic               ld_full;
  logic               pk_push;
  logic               pk_clr;
  logic               pk_we;
  logic [31:0]        pk_wdata;
  logic               addr_err;
  logic [31:0]        rsp_data;

  assign is_idle  = (state == IDLE);
  assign is_busy  = (state == BUSY);
  assign is_load  = (state == LOAD);
  assign rsp_slot = is_busy && (cnt == '0);

  // A load request in IDLE wins, so the port is not offered in that cycle
  assign req_ready = !flush && ((is_idle && !ld_start) || rsp_slot);
  assign acc       = req_valid && req_ready;
  assign rsp_fire  = rsp_slot && !flush;

  assign ld_full  = (ld_len == LEN_FULL);
  assign pk_push  = is_load && ld_valid && !ld_start && !ld_full;
  assign pk_clr   = ld_start && !is_busy;

  // Any address at or past the loaded length errors; high address bits beyond
  // the RAM always land there because ld_len never exceeds the RAM depth
  assign addr_err = (req_addr >= {{(30 - LEN_W){1'b0}}, ld_len});
  assign rsp_data = err_q ? NOP_INST : ram_q;

  assign rsp_valid = rsp_fire;
  assign rsp_inst  = rsp_fire ? rsp_data : inst_hold;
  assign rsp_err   = rsp_fire ? err_q    : err_hold;
  assign ld_ready  = is_load;
  assign ld_done   = ld_done_q;
  assign ld_ovf    = ld_ovf_q;

  ld_word_packer u_packer (
    .clk   (clk),
    .rst   (rst),
    .clr   (pk_clr),
    .push  (pk_push),
    .last  (ld_last),
    .din   (ld_byte),
    .we    (pk_we),
    .wdata (pk_wdata)
  );

  // Control FSM: fetch latency counter, load session length and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ld_len    <= '0;
      ld_done_q <= 1'b0;
      ld_ovf_q  <= 1'b0;
    end else begin
      if (pk_we) ld_len <= ld_len + 1'b1;
      case (state)
        IDLE: begin
          if (ld_start) begin
            state     <= LOAD;
            ld_len    <= '0;
            ld_done_q <= 1'b0;
            ld_ovf_q  <= 1'b0;
          end else if (acc) begin
            state <= BUSY;
            cnt   <= CNT_LOAD;
          end
        end
        BUSY: begin
          if (flush) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            if (acc) cnt   <= CNT_LOAD;
            else     state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        LOAD: begin
          if (ld_start) begin
            ld_len    <= '0;
            ld_done_q <= 1'b0;
            ld_ovf_q  <= 1'b0;
          end else if (ld_valid) begin
            if (ld_full) ld_ovf_q <= 1'b1;
            if (ld_last) begin
              ld_done_q <= 1'b1;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Single-port RAM: writes only while loading, reads only on fetch acceptance
  always_ff @(posedge clk) begin
    if (pk_we) mem[ld_len[ADDR_W-1:0]] <= pk_wdata;
    if (acc)   ram_q <= mem[req_addr[ADDR_W-1:0]];
  end

  // Range check captured with the read so it matches the data in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      err_q <= 1'b0;
    else if (acc) err_q <= addr_err;
  end

  // Last delivered response, presented on the outputs between responses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_hold <= '0;
      err_hold  <= 1'b0;
    end else if (rsp_fire) begin
      inst_hold <= rsp_data;
      err_hold  <= err_q;
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder (small RAM so overflow is reachable).
module tb_imem_responder;

  localparam int ADDR_W  = 2;
  localparam int LATENCY = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [29:0] req_addr = '0;
  logic        flush = 1'b0;
  logic        rsp_valid;
  logic [31:0] rsp_inst;
  logic        rsp_err;
  logic        ld_start = 1'b0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_byte = '0;
  logic        ld_last = 1'b0;
  logic        ld_ready;
  logic        ld_done;
  logic        ld_ovf;

  always #5 clk = ~clk;

  imem_responder #(
    .ADDR_W   (ADDR_W),
    .LATENCY  (LATENCY),
    .NOP_INST (32'h0000_0013)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .flush     (flush),
    .rsp_valid (rsp_valid),
    .rsp_inst  (rsp_inst),
    .rsp_err   (rsp_err),
    .ld_start  (ld_start),
    .ld_valid  (ld_valid),
    .ld_byte   (ld_byte),
    .ld_last   (ld_last),
    .ld_ready  (ld_ready),
    .ld_done   (ld_done),
    .ld_ovf    (ld_ovf)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  logic [7:0] prog [0:19];

  // One load session: ld_start cycle, then n bytes with ld_last on the final one
  task automatic load_prog(input int n);
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'b1;
      ld_byte  = prog[i];
      ld_last  = (i == n - 1);
      if (i == 0) begin
        mid();
        chk1("ld_ready_in_load", ld_ready, 1'b1);
      end
      step();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  // Single fetch from IDLE; response expected exactly LATENCY cycles later
  task automatic fetch(input logic [29:0] a, input logic [31:0] ei, input logic ee,
                       input string name);
    req_valid = 1'b1;
    req_addr  = a;
    mid();
    chk1({name, "_ready"}, req_ready, 1'b1);
    step();
    req_valid = 1'b0;
    for (int k = 1; k <= LATENCY; k++) begin
      mid();
      if (k < LATENCY) begin
        chk1({name, "_early_valid"}, rsp_valid, 1'b0);
      end else begin
        chk1({name, "_valid"}, rsp_valid, 1'b1);
        chk({name, "_inst"}, rsp_inst, ei);
        chk1({name, "_err"}, rsp_err, ee);
      end
      step();
    end
  endtask

  typedef struct {
    logic [29:0] addr;
    logic [31:0] inst;
    logic        err;
  } fvec_t;

  fvec_t tab [0:8];

  initial begin
    // Program 1 (8 bytes) then program 2 (5 bytes, partial last word)
    tab[0] = '{30'd0,          32'h0000_0013, 1'b0};
    tab[1] = '{30'd1,          32'h0010_0093, 1'b0};
    tab[2] = '{30'd2,          32'h0000_0013, 1'b1};
    tab[3] = '{30'd3,          32'h0000_0013, 1'b1};
    tab[4] = '{30'd4,          32'h0000_0013, 1'b1};
    tab[5] = '{30'h2000_0001,  32'h0000_0013, 1'b1};
    tab[6] = '{30'd0,          32'h4433_2211, 1'b0};
    tab[7] = '{30'd1,          32'h0000_00AA, 1'b0};
    tab[8] = '{30'd2,          32'h0000_0013, 1'b1};

    // Reset state
    #2 rst = 1'b1;
    mid();
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_inst", rsp_inst, 32'h0);
    chk1("rst_rsp_err", rsp_err, 1'b0);
    chk1("rst_ld_done", ld_done, 1'b0);
    chk1("rst_ld_ovf", ld_ovf, 1'b0);
    chk1("rst_ld_ready", ld_ready, 1'b0);
    chk1("rst_req_ready", req_ready, 1'b1);
    step();
    rst = 1'b0;
    step();

    // Load then fetch
    prog[0] = 8'h13; prog[1] = 8'h00; prog[2] = 8'h00; prog[3] = 8'h00;
    prog[4] = 8'h93; prog[5] = 8'h00; prog[6] = 8'h10; prog[7] = 8'h00;
    load_prog(8);
    mid();
    chk1("p1_ld_done", ld_done, 1'b1);
    chk1("p1_ld_ovf", ld_ovf, 1'b0);
    chk1("p1_ld_ready_idle", ld_ready, 1'b0);
    chk("p1_ld_len", 32'(dut.ld_len), 32'd2);
    step();
    for (int i = 0; i <= 5; i++)
      fetch(tab[i].addr, tab[i].inst, tab[i].err, $sformatf("vec%0d", i));

    // Partial word and out-of-range
    prog[0] = 8'h11; prog[1] = 8'h22; prog[2] = 8'h33; prog[3] = 8'h44; prog[4] = 8'hAA;
    load_prog(5);
    mid();
    chk("p2_ld_len", 32'(dut.ld_len), 32'd2);
    step();
    for (int i = 6; i <= 8; i++)
      fetch(tab[i].addr, tab[i].inst, tab[i].err, $sformatf("vec%0d", i));

    // Back-to-back fetches with req_valid held high
    req_valid = 1'b1; req_addr = 30'd0;
    mid(); chk1("b2b_c0_ready", req_ready, 1'b1); chk1("b2b_c0_valid", rsp_valid, 1'b0);
    step(); req_addr = 30'd1;
    mid(); chk1("b2b_c1_ready", req_ready, 1'b0); chk1("b2b_c1_valid", rsp_valid, 1'b0);
    step();
    mid(); chk1("b2b_c2_ready", req_ready, 1'b1); chk1("b2b_c2_valid", rsp_valid, 1'b1);
    chk("b2b_c2_inst", rsp_inst, 32'h4433_2211);
    step(); req_addr = 30'd2;
    mid(); chk1("b2b_c3_ready", req_ready, 1'b0); chk1("b2b_c3_valid", rsp_valid, 1'b0);
    step();
    mid(); chk1("b2b_c4_ready", req_ready, 1'b1); chk1("b2b_c4_valid", rsp_valid, 1'b1);
    chk("b2b_c4_inst", rsp_inst, 32'h0000_00AA); chk1("b2b_c4_err", rsp_err, 1'b0);
    step(); req_valid = 1'b0;
    mid(); chk1("b2b_c5_ready", req_ready, 1'b0); chk1("b2b_c5_valid", rsp_valid, 1'b0);
    step();
    mid(); chk1("b2b_c6_valid", rsp_valid, 1'b1);
    chk("b2b_c6_inst", rsp_inst, 32'h0000_0013); chk1("b2b_c6_err", rsp_err, 1'b1);
    step();
    mid(); chk1("b2b_c7_valid", rsp_valid, 1'b0); chk1("b2b_c7_ready", req_ready, 1'b1);
    chk("b2b_c7_hold_inst", rsp_inst, 32'h0000_0013); chk1("b2b_c7_hold_err", rsp_err, 1'b1);
    step();

    // Flush the cycle after acceptance; a new request follows
    req_valid = 1'b1; req_addr = 30'd0;
    step();
    flush = 1'b1; req_addr = 30'd1;
    mid(); chk1("flA_c1_ready", req_ready, 1'b0); chk1("flA_c1_valid", rsp_valid, 1'b0);
    step(); flush = 1'b0;
    mid(); chk1("flA_c2_ready", req_ready, 1'b1); chk1("flA_c2_valid", rsp_valid, 1'b0);
    chk("flA_c2_hold_inst", rsp_inst, 32'h0000_0013);
    step(); req_valid = 1'b0;
    mid(); chk1("flA_c3_valid", rsp_valid, 1'b0);
    step();
    mid(); chk1("flA_c4_valid", rsp_valid, 1'b1); chk("flA_c4_inst", rsp_inst, 32'h0000_00AA);
    step();

    // Flush in the response cycle itself
    req_valid = 1'b1; req_addr = 30'd0;
    step(); req_valid = 1'b0;
    mid(); chk1("flB_c1_valid", rsp_valid, 1'b0);
    step(); flush = 1'b1;
    mid(); chk1("flB_c2_valid", rsp_valid, 1'b0); chk1("flB_c2_ready", req_ready, 1'b0);
    chk("flB_c2_hold_inst", rsp_inst, 32'h0000_00AA);
    step(); flush = 1'b0;
    mid(); chk1("flB_c3_valid", rsp_valid, 1'b0); chk1("flB_c3_ready", req_ready, 1'b1);
    step();

    // Reset in the middle of a load discards the partial word
    ld_start = 1'b1; step(); ld_start = 1'b0;
    ld_valid = 1'b1; ld_byte = 8'h77; step();
    ld_byte = 8'h66; step();
    ld_valid = 1'b0; rst = 1'b1;
    mid(); chk1("rstL_ld_ready", ld_ready, 1'b0);
    step(); rst = 1'b0;
    step();
    prog[0] = 8'h55;
    load_prog(1);
    fetch(30'd0, 32'h0000_0055, 1'b0, "rstL_fetch0");

    // Overflow: 20 bytes into a 4-word RAM
    for (int i = 0; i < 20; i++) prog[i] = 8'(i);
    load_prog(20);
    mid();
    chk1("ovf_ld_ovf", ld_ovf, 1'b1);
    chk1("ovf_ld_done", ld_done, 1'b1);
    chk("ovf_ld_len", 32'(dut.ld_len), 32'd4);
    step();
    fetch(30'd3, 32'h0F0E_0D0C, 1'b0, "ovf_fetch3");
    fetch(30'd0, 32'h0302_0100, 1'b0, "ovf_fetch0");
    fetch(30'd4, 32'h0000_0013, 1'b1, "ovf_fetch4");

    // Restarting a session clears the sticky flags
    ld_start = 1'b1; step(); ld_start = 1'b0;
    mid();
    chk1("restart_ld_ovf", ld_ovf, 1'b0);
    chk1("restart_ld_done", ld_done, 1'b0);
    chk1("restart_ld_ready", ld_ready, 1'b1);
    ld_valid = 1'b1; ld_last = 1'b1; ld_byte = 8'h99;
    step();
    ld_valid = 1'b0; ld_last = 1'b0;
    fetch(30'd0, 32'h0000_0099, 1'b0, "restart_fetch0");

    // Reset while a fetch is in flight
    req_valid = 1'b1; req_addr = 30'd0;
    step(); req_valid = 1'b0; rst = 1'b1;
    mid();
    chk1("rstB_valid", rsp_valid, 1'b0);
    chk("rstB_inst", rsp_inst, 32'h0);
    chk1("rstB_ld_done", ld_done, 1'b0);
    step(); rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      mid();
      chk1($sformatf("rstB_quiet%0d", k), rsp_valid, 1'b0);
      step();
    end
    mid();
    chk("rstB_ld_len", 32'(dut.ld_len), 32'd0);
    step();
    fetch(30'd0, 32'h0000_0013, 1'b1, "rstB_fetch0");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
